// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer for the UART TX path.
// Accepts bytes over a valid/ready handshake, generates the baud tick and
// drives the load/enable/key inputs of the 10-bit TX shift register
// (start bit, D0..D7 LSB-first, stop bit).
//
// Optional feature macro: UART_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   FIFO_DEPTH    input FIFO entries (power of two, >= 2), FIFO build only
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   tx_data       byte to send
//   tx_valid      tx_data is valid
//   tx_ready      byte accepted on this cycle's edge when tx_valid is high
//   shift_load    one-cycle load strobe to the shift register
//   shift_key     byte presented to the shift register (valid with shift_load)
//   shift_enable  one-cycle bit-tick strobe to the shift register
//   busy          frame in progress
//   done          one-cycle pulse when the stop bit period ends
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       shift_load,
    output logic [7:0] shift_key,
    output logic       shift_enable,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT = 4'd9;

    // Elaboration-time parameter sanity checks.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_ctrl: CLKS_PER_BIT out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [3:0]          bitn_q, bitn_d;
    logic [7:0]          hold_q, hold_d;
    logic                tx_ready_q, tx_ready_d;
    logic                shift_load_q, shift_load_d;
    logic [7:0]          shift_key_q, shift_key_d;
    logic                shift_enable_q, shift_enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                push;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    logic             bypass;
`endif

    // Ready is registered but forced low for the whole reset cycle.
    assign tx_ready     = tx_ready_q && !reset;
    assign shift_load   = shift_load_q;
    assign shift_key    = shift_key_q;
    assign shift_enable = shift_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Next-state, counters, FIFO bookkeeping and next-cycle outputs.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bitn_d  = bitn_q;
        hold_d  = hold_q;
        push    = tx_valid && tx_ready;
`ifdef UART_TX_FIFO_EN
        pop      = 1'b0;
        bypass   = 1'b0;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_FIFO_EN
                // Empty FIFO and idle FSM: take the byte straight into hold.
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = S_LOAD;
                end else if (push) begin
                    bypass  = 1'b1;
                    hold_d  = tx_data;
                    state_d = S_LOAD;
                end
`else
                if (push) begin
                    hold_d  = tx_data;
                    state_d = S_LOAD;
                end
`endif
            end
            S_LOAD: begin
                bcnt_d  = '0;
                bitn_d  = 4'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bcnt_q == BCNT_MAX) begin
                    bcnt_d = '0;
                    if (bitn_q == LAST_BIT) begin
                        state_d = S_IDLE;
`ifdef UART_TX_FIFO_EN
                        // Chain the next queued byte with no idle cycle.
                        if (cnt_q != '0) begin
                            pop     = 1'b1;
                            hold_d  = mem_q[rd_ptr_q];
                            state_d = S_LOAD;
                        end
`endif
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_TX_FIFO_EN
        if (push && !bypass) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d      = cnt_q + CNT_W'(push && !bypass) - CNT_W'(pop);
        tx_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH));
`else
        tx_ready_d = (state_d == S_IDLE);
`endif

        // Outputs are registered copies of what the next state implies.
        shift_load_d   = (state_d == S_LOAD);
        shift_key_d    = (state_d == S_LOAD) ? hold_d : shift_key_q;
        shift_enable_d = (state_d == S_SHIFT) && (bcnt_d == BCNT_MAX);
        done_d         = shift_enable_d && (bitn_d == LAST_BIT);
        busy_d         = (state_d != S_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bcnt_q         <= '0;
            bitn_q         <= 4'd0;
            hold_q         <= 8'h00;
            tx_ready_q     <= 1'b1;
            shift_load_q   <= 1'b0;
            shift_key_q    <= 8'h00;
            shift_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef UART_TX_FIFO_EN
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            bcnt_q         <= bcnt_d;
            bitn_q         <= bitn_d;
            hold_q         <= hold_d;
            tx_ready_q     <= tx_ready_d;
            shift_load_q   <= shift_load_d;
            shift_key_q    <= shift_key_d;
            shift_enable_q <= shift_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef UART_TX_FIFO_EN
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
`endif
        end
    end

`ifdef UART_TX_FIFO_EN
    // FIFO storage; emptied logically by the pointer reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (CLKS_PER_BIT 4 and 2) share the
// stimulus; a frame-level model predicts every output each cycle, and
// directed checks pin frame length, serial bit order and chaining.
module tb_uart_tx_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 300;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;

    logic       ready [2];
    logic       sload [2];
    logic [7:0] skey  [2];
    logic       sen   [2];
    logic       busy  [2];
    logic       done  [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model state: one frame in flight per instance, starting at lc[i].
    int         cpb  [2] = '{4, 2};
    bit         act  [2] = '{1'b0, 1'b0};
    int         lc   [2] = '{0, 0};
    logic [7:0] kexp [2] = '{8'h00, 8'h00};
`ifdef UART_TX_FIFO_EN
    logic [7:0] fbuf [2][DEPTH];
    int         fcnt [2] = '{0, 0};
`endif

    // Observation logs (instance 0 unless noted).
    int         loads0 [$];
    int         keys0  [$];
    int         dones0 [$];
    int         runs0  [$];
    int         runs1  [$];
    bit         line_q [$];
    int         en_cnt0 = 0;
    logic [9:0] sr0     = 10'h3FF;
    int         run       [2] = '{0, 0};
    bit         abort_run [2] = '{1'b0, 1'b0};

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[0]), .shift_load(sload[0]), .shift_key(skey[0]),
        .shift_enable(sen[0]), .busy(busy[0]), .done(done[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready[1]), .shift_load(sload[1]), .shift_key(skey[1]),
        .shift_enable(sen[1]), .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s[%0d] cycle %0d: got %0h want %0h", nm, idx, cyc, got, want);
        end
    endtask

    function automatic int qget(input int q [$], input int idx);
        return (idx >= 0 && idx < q.size()) ? q[idx] : -999;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : model_chk
        int d;
        bit xl, xe, xd, xb, xr, push;
        for (int i = 0; i < 2; i++) begin
            d  = cyc - lc[i];
            xb = act[i];
            xl = xb && (d == 0);
            xe = xb && (d > 0) && (d % cpb[i] == 0);
            xd = xb && (d == 10 * cpb[i]);
`ifdef UART_TX_FIFO_EN
            xr = !reset && (fcnt[i] < DEPTH);
`else
            xr = !reset && !xb;
`endif
            if (cyc >= 1) begin
                chk("tx_ready", i, 32'(ready[i]), 32'(xr));
                chk("shift_load", i, 32'(sload[i]), 32'(xl));
                chk("shift_key", i, 32'(skey[i]), 32'(kexp[i]));
                chk("shift_enable", i, 32'(sen[i]), 32'(xe));
                chk("busy", i, 32'(busy[i]), 32'(xb));
                chk("done", i, 32'(done[i]), 32'(xd));
            end
            if (reset) begin
                act[i]  = 1'b0;
                kexp[i] = 8'h00;
`ifdef UART_TX_FIFO_EN
                fcnt[i] = 0;
`endif
            end else begin
                push = tx_valid && xr;
                if (xd) act[i] = 1'b0;
`ifdef UART_TX_FIFO_EN
                if (!act[i] && fcnt[i] > 0) begin
                    act[i]  = 1'b1;
                    lc[i]   = cyc + 1;
                    kexp[i] = fbuf[i][0];
                    for (int j = 0; j < DEPTH - 1; j++) fbuf[i][j] = fbuf[i][j+1];
                    fcnt[i]--;
                end else if (!xb && push) begin
                    act[i]  = 1'b1;
                    lc[i]   = cyc + 1;
                    kexp[i] = tx_data;
                    push    = 1'b0;
                end
                if (push) begin
                    fbuf[i][fcnt[i]] = tx_data;
                    fcnt[i]++;
                end
`else
                if (push) begin
                    act[i]  = 1'b1;
                    lc[i]   = cyc + 1;
                    kexp[i] = tx_data;
                end
`endif
            end
            // Busy run lengths; runs cut by reset are discarded.
            if (busy[i] === 1'b1) begin
                run[i]++;
            end else if (run[i] > 0) begin
                if (!abort_run[i]) begin
                    if (i == 0) runs0.push_back(run[i]);
                    else        runs1.push_back(run[i]);
                end
                run[i]       = 0;
                abort_run[i] = 1'b0;
            end
            if (reset && run[i] > 0) abort_run[i] = 1'b1;
        end
        // Instance 0 event log and a reference 10-bit shift register.
        if (sen[0] === 1'b1) begin
            line_q.push_back(sr0[0]);
            sr0 = {1'b1, sr0[9:1]};
            en_cnt0++;
        end
        if (sload[0] === 1'b1) begin
            sr0 = {1'b1, skey[0], 1'b0};
            loads0.push_back(cyc);
            keys0.push_back(int'(skey[0]));
        end
        if (done[0] === 1'b1) dones0.push_back(cyc);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a byte until instance 0 takes it, then drop tx_valid.
    task automatic send(input logic [7:0] b);
        int t;
        t        = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!ready[0] && t < TMO) begin
            tick(1);
            t++;
        end
        chk("send_timeout", int'(b), 32'(t >= TMO), 32'd0);
        tick(1);
        tx_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit exp_line [10];
        int base, n0, d0, t, lq;
        exp_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        tick(3);
        reset = 1'b0;
        tick(2);

        // Single 0xA5 frame on both instances.
        send(8'hA5);
        tick(50);
        for (int k = 0; k < 10; k++) begin
            chk("line_bit", k, (k < line_q.size()) ? 32'(line_q[k]) : 32'hFFFF,
                32'(exp_line[k]));
        end
        chk("t1_key", 0, 32'(qget(keys0, 0)), 32'h0000_00A5);
        chk("t1_load_to_done", 0, 32'(qget(dones0, 0) - qget(loads0, 0)), 32'd40);
        chk("t1_ticks", 0, 32'(en_cnt0), 32'd10);
        chk("t1_busy_len_c4", 0, 32'(qget(runs0, 0)), 32'd41);
        chk("t1_busy_len_c2", 1, 32'(qget(runs1, 0)), 32'd21);

`ifndef UART_TX_FIFO_EN
        // Held valid: 0x01 then 0x02; second LOAD two cycles after done.
        n0 = loads0.size();
        d0 = dones0.size();
        send(8'h01);
        send(8'h02);
        tick(100);
        chk("t2_key1", 0, 32'(qget(keys0, n0)), 32'h01);
        chk("t2_key2", 0, 32'(qget(keys0, n0 + 1)), 32'h02);
        chk("t2_done_to_load", 0, 32'(qget(loads0, n0 + 1) - qget(dones0, d0)), 32'd2);
        chk("t2_busy_len", 0, 32'(qget(runs0, 1)), 32'd41);
`else
        // Five pushes 0x10..0x14; frames chained with no idle cycle.
        n0 = loads0.size();
        d0 = dones0.size();
        for (int b = 0; b < 5; b++) send(8'(8'h10 + b));
        tick(230);
        for (int j = 0; j < 5; j++) begin
            chk("t3_key", j, 32'(qget(keys0, n0 + j)), 32'(8'h10 + j));
        end
        for (int j = 0; j < 4; j++) begin
            chk("t3_chain", j, 32'(qget(loads0, n0 + j + 1) - qget(dones0, d0 + j)), 32'd1);
        end
        // Push on the done cycle while one entry is queued.
        n0 = loads0.size();
        d0 = dones0.size();
        send(8'h31);
        send(8'h32);
        lq = qget(loads0, n0);
        t  = 0;
        while (cyc != lq + 40 && t < TMO) begin
            tick(1);
            t++;
        end
        chk("t4_wait_done", 0, 32'(t >= TMO), 32'd0);
        send(8'h33);
        tick(100);
        chk("t4_key2", 0, 32'(qget(keys0, n0 + 1)), 32'h32);
        chk("t4_key3", 0, 32'(qget(keys0, n0 + 2)), 32'h33);
        chk("t4_chain1", 0, 32'(qget(loads0, n0 + 1) - qget(dones0, d0)), 32'd1);
        chk("t4_chain2", 0, 32'(qget(loads0, n0 + 2) - qget(dones0, d0 + 1)), 32'd1);
`endif

        // Reset three ticks into a frame, then a clean frame.
        base = en_cnt0;
        send(8'h5A);
        t = 0;
        while (en_cnt0 < base + 3 && t < TMO) begin
            tick(1);
            t++;
        end
        chk("t5_wait_ticks", 0, 32'(t >= TMO), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(50);
        chk("t5_no_tick_after_reset", 0, 32'(en_cnt0), 32'(base + 3));
        n0 = runs0.size();
        send(8'h3C);
        tick(60);
        chk("t5_full_frame_ticks", 0, 32'(en_cnt0), 32'(base + 13));
        chk("t5_key", 0, 32'(qget(keys0, keys0.size() - 1)), 32'h3C);
        chk("t5_busy_len", 0, 32'(qget(runs0, n0)), 32'd41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
